updw_sweep_ctrl: RTL and testbench
==================================

# updw_sweep_ctrl

Sequencer that drives a bounded up/down count sweep on demand. It replaces a free-running 0→7→0 counter FSM with a start/busy/done controlled engine. The controller latches programmable low/high bounds and a sweep count, runs the triangle sequence, supports pause, flags illegal configurations, and pulses done on completion. It sits between the control FSM, which issues `start`, and the downstream consumer of `count`.

## Interface
- `WIDTH`, default 3: width of bounds and count.
- `clk` input 1: system clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `start` input [1]: request a sweep run; sampled only in IDLE.
- `pause` input [1]: freeze sequencing while high (UP/DOWN only).
- `lo` input [WIDTH]: low bound, latched on accepted start.
- `hi` input [WIDTH]: high bound, latched on accepted start.
- `n_sweeps` input [4]: number of full sweeps, latched on accepted start.
- `count` output [WIDTH]: current sequence value.
- `dir` output [1]: 0 while counting up or idle, 1 while counting down.
- `busy` output [1]: high in UP/DOWN.
- `done` output [1]: one-cycle pulse on normal completion.
- `err` output [1]: one-cycle pulse on a rejected start.

## Operation
- States: IDLE, UP, DOWN. Registers: `state`, `count`, latched `lo_q`/`hi_q`/`n_q`, and 4-bit `sweeps`.
- IDLE + `start`=1:
  - If `lo >= hi` or `n_sweeps == 0`: `err`=1 next cycle; stay IDLE; `count` unchanged.
  - Otherwise: latch bounds; `count <= lo`; `sweeps <= 0`; go UP.
- UP, not paused:
  - If `count == hi_q`: `count <= hi_q-1`; go DOWN.
  - Otherwise: `count <= count+1`.
- DOWN, not paused:
  - If `count != lo_q`: `count <= count-1`.
  - If `count == lo_q` and `sweeps+1 == n_q`: go IDLE; `done`=1 next cycle; `count` holds `lo_q`.
  - If `count == lo_q` and more sweeps remain: `sweeps <= sweeps+1`; `count <= lo_q+1`; go UP.
- Each sweep emits `lo..hi..lo`. `hi` appears once per sweep. `lo` appears once between consecutive sweeps.
- `pause` holds `state`, `count` and `sweeps`. Pause overrides every transition, including the final one. `pause` is ignored in IDLE.
- `start` is ignored while `busy`=1.
- Arithmetic stays within WIDTH. The `lo < hi` check rules out wrap-around, so `hi = 2^WIDTH-1` is legal.
- `busy` = (state != IDLE). `dir` = (state == DOWN). Both are decoded from registered state.

## Timing
- Reset values: state IDLE; `count`=0, `dir`=0, `busy`=0, `done`=0, `err`=0, `sweeps`=0.
- Reset mid-run returns to IDLE on the next edge with no `done` pulse.
- Accepted start at edge k: cycle k+1 shows `busy`=1 and `count`=`lo`.
- Unpaused run length: `busy` is high for 2·(hi−lo)·n + 1 cycles. `done` is high in the cycle after the last `lo` is shown, with `busy`=0 in that same cycle.
- `err` and `done` are registered single-cycle pulses and never assert together.
- `start` held high through completion is not seen until the cycle `done` is high, which is the IDLE cycle. A back-to-back restart is therefore accepted at that edge.

## Configuration
- `UPDW_SWEEP_ABORT_EN` defined: adds input `abort` [1]. `abort`=1 in UP/DOWN forces IDLE and `count <= lo_q` on the next edge, with no `done`. `abort` has priority over `pause`. `abort` is ignored in IDLE.
- `UPDW_SWEEP_ABORT_EN` undefined: no `abort` port; only reset interrupts a run.

## Test plan
- Reset, then start with lo=0, hi=7, n=1:
  - `count` = 0,1,…,7,6,…,0 over 15 busy cycles.
  - `done` pulses in cycle 16 with `count`=0.
- Start with lo=2, hi=5, n=2:
  - `count` = 2,3,4,5,4,3,2,3,4,5,4,3,2 with `dir` matching.
  - `done` pulses after 13 busy cycles.
- Rejected starts: start with lo=5, hi=5, n=3, then with lo=1, hi=4, n=0. Each gives an `err` pulse, `busy` stays 0 and `count` is unchanged.
- Pause and ignored start: run lo=0, hi=7, n=1; pause for 3 cycles at `count`=4 while going up, and pulse `start` mid-run. The value 4 is held for 4 cycles, `start` has no effect, and `done` comes 3 cycles later than unpaused.
- Reset mid-run: assert reset while `count`=6 going down. Next cycle shows state IDLE, `count`=0, all flags 0, and no `done`.
- Abort (macro on): assert `abort` at `count`=3, including with `pause` high. Next cycle shows IDLE, `count`=`lo`, and no `done`.

Source files
------------

// File: rtl/updw_sweep_ctrl.sv
// Bounded up/down sweep sequencer (lo..hi..lo, n times); `UPDW_SWEEP_ABORT_EN adds an abort input.
// Latency: accepted start shows count=lo next cycle; no backpressure: pause freezes sequencing, start is ignored while busy.
module updw_sweep_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
`ifdef UPDW_SWEEP_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       n_sweeps,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [3:0]       n_q, n_d;
    logic [3:0]       sweeps, sweeps_d;
    logic             done_d;
    logic             err_d;
    logic             abort_req;

`ifdef UPDW_SWEEP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        count_d  = count;
        lo_d     = lo_q;
        hi_d     = hi_q;
        n_d      = n_q;
        sweeps_d = sweeps;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // lo < hi guarantees hi-1 and lo+1 never wrap
                    if ((lo >= hi) || (n_sweeps == 4'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d     = lo;
                        hi_d     = hi;
                        n_d      = n_sweeps;
                        count_d  = lo;
                        sweeps_d = 4'd0;
                        state_d  = UP;
                    end
                end
            end
            UP: begin
                if (abort_req) begin
                    state_d = IDLE;
                    count_d = lo_q;
                end else if (!pause) begin
                    if (count == hi_q) begin
                        count_d = hi_q - ONE;
                        state_d = DOWN;
                    end else begin
                        count_d = count + ONE;
                    end
                end
            end
            DOWN: begin
                if (abort_req) begin
                    state_d = IDLE;
                    count_d = lo_q;
                end else if (!pause) begin
                    if (count != lo_q) begin
                        count_d = count - ONE;
                    end else if (4'(sweeps + 4'd1) == n_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        sweeps_d = sweeps + 4'd1;
                        count_d  = lo_q + ONE;
                        state_d  = UP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            n_q    <= 4'd0;
            sweeps <= 4'd0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            n_q    <= n_d;
            sweeps <= sweeps_d;
            done   <= done_d;
            err    <= err_d;
        end
    end

    assign busy = (state != IDLE);
    assign dir  = (state == DOWN);

endmodule

// File: tb/tb_updw_sweep_ctrl.sv
// Vector-table bench for updw_sweep_ctrl; expected outputs queued at drive time, popped one cycle later.
module tb_updw_sweep_ctrl;

    typedef struct {
        int         id;
        logic       rst;
        logic       start;
        logic       pause;
        logic       abort;
        logic [2:0] lo;
        logic [2:0] hi;
        logic [3:0] n;
        logic [2:0] e_count;
        logic       e_dir;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] n_sweeps;
    logic [2:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
`ifdef UPDW_SWEEP_ABORT_EN
    logic       abort;
`endif

    vec_t vecs[$];
    vec_t sb[$];
    int   cur_id;
    int   passed;
    int   total;

    updw_sweep_ctrl #(.WIDTH(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
`ifdef UPDW_SWEEP_ABORT_EN
        .abort    (abort),
`endif
        .lo       (lo),
        .hi       (hi),
        .n_sweeps (n_sweeps),
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic st, input logic pz, input logic ab,
                                input logic [2:0] l, input logic [2:0] h, input logic [3:0] n,
                                input logic [2:0] ec, input logic ed, input logic eb,
                                input logic edn, input logic eer);
        vec_t v;
        v.id = cur_id;
        v.rst = r;
        v.start = st;
        v.pause = pz;
        v.abort = ab;
        v.lo = l;
        v.hi = h;
        v.n = n;
        v.e_count = ec;
        v.e_dir = ed;
        v.e_busy = eb;
        v.e_done = edn;
        v.e_err = eer;
        return v;
    endfunction

    // One busy-cycle vector of a run; a stray start carries an otherwise legal, different config.
    task automatic body_vec(input logic [2:0] l, input logic [2:0] h, input logic [3:0] n,
                            input int v, input logic d, input logic stray, input logic hold);
        if (stray)
            vecs.push_back(mk(0, 1, 0, 0, 3'd1, 3'd6, 4'd5, 3'(v), d, 1, 0, 0));
        else
            vecs.push_back(mk(0, hold, 0, 0, l, h, n, 3'(v), d, 1, 0, 0));
    endtask

    // Full run: start, n triangles lo..hi..lo, then the done cycle; optional pause while rising at pz_at.
    task automatic add_run(input logic [2:0] l, input logic [2:0] h, input logic [3:0] n,
                           input int pz_at, input int pz_len, input int stray_k, input logic hold);
        int   k;
        logic paused;
        k = 0;
        paused = 1'b0;
        vecs.push_back(mk(0, 1, 0, 0, l, h, n, l, 0, 1, 0, 0));
        for (int s = 0; s < int'(n); s++) begin
            for (int v = int'(l) + 1; v <= int'(h); v++) begin
                k++;
                body_vec(l, h, n, v, 1'b0, k == stray_k, hold);
                if (v == pz_at && !paused) begin
                    paused = 1'b1;
                    for (int p = 0; p < pz_len; p++)
                        vecs.push_back(mk(0, hold, 1, 0, l, h, n, 3'(v), 0, 1, 0, 0));
                end
            end
            for (int v = int'(h) - 1; v >= int'(l); v--) begin
                k++;
                body_vec(l, h, n, v, 1'b1, k == stray_k, hold);
            end
        end
        vecs.push_back(mk(0, hold, 0, 0, l, h, n, l, 0, 0, 1, 0));
    endtask

    task automatic chk(input vec_t e);
        logic [6:0] act;
        logic [6:0] exp;
        act = {count, dir, busy, done, err};
        exp = {e.e_count, e.e_dir, e.e_busy, e.e_done, e.e_err};
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL test%0d chk%0d count/dir/busy/done/err: got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                     e.id, total, count, dir, busy, done, err,
                     e.e_count, e.e_dir, e.e_busy, e.e_done, e.e_err);
    endtask

    task automatic drive(input vec_t v);
        reset    = v.rst;
        start    = v.start;
        pause    = v.pause;
        lo       = v.lo;
        hi       = v.hi;
        n_sweeps = v.n;
`ifdef UPDW_SWEEP_ABORT_EN
        abort    = v.abort;
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;

        // Power-on reset, checked by hand before the table runs.
        cur_id = 0;
        drive(mk(1, 1, 1, 1, 3'd3, 3'd6, 4'd2, 3'd0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(mk(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));

        // Full 0..7..0 sweep, then two 2..5..2 sweeps.
        cur_id = 1;
        add_run(3'd0, 3'd7, 4'd1, -1, 0, 0, 1'b0);
        cur_id = 2;
        add_run(3'd2, 3'd5, 4'd2, -1, 0, 0, 1'b0);

        // Rejected configurations leave count at the previous lo.
        cur_id = 3;
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 3'd2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd5, 3'd5, 4'd3, 3'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 3'd5, 3'd5, 4'd3, 3'd2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd1, 3'd4, 4'd0, 3'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 3'd6, 3'd2, 4'd4, 3'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 3'd6, 3'd2, 4'd4, 3'd2, 0, 0, 0, 0));

        // Pause 3 cycles at 4 while rising; stray start on the way down.
        cur_id = 4;
        add_run(3'd0, 3'd7, 4'd1, 4, 3, 10, 1'b0);

        // Start held through a run, back-to-back restart, then 15 sweeps.
        cur_id = 5;
        add_run(3'd6, 3'd7, 4'd1, -1, 0, 0, 1'b1);
        add_run(3'd3, 3'd4, 4'd15, -1, 0, 0, 1'b0);

        // Pause ignored in IDLE; reset while falling at 6.
        cur_id = 6;
        vecs.push_back(mk(0, 1, 1, 0, 3'd0, 3'd7, 4'd1, 3'd0, 0, 1, 0, 0));
        for (int v = 1; v <= 7; v++)
            vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd7, 4'd1, 3'(v), 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd7, 4'd1, 3'd6, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'd0, 3'd7, 4'd1, 3'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd7, 4'd1, 3'd0, 0, 0, 0, 0));

        // Pause holds the final lo and delays done.
        cur_id = 7;
        vecs.push_back(mk(0, 1, 0, 0, 3'd4, 3'd5, 4'd1, 3'd4, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd4, 3'd5, 4'd1, 3'd5, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd4, 3'd5, 4'd1, 3'd4, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3'd4, 3'd5, 4'd1, 3'd4, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3'd4, 3'd5, 4'd1, 3'd4, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd4, 3'd5, 4'd1, 3'd4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd4, 3'd5, 4'd1, 3'd4, 0, 0, 0, 0));

`ifdef UPDW_SWEEP_ABORT_EN
        // Abort at 3 while rising with pause high, and at 3 while falling.
        cur_id = 8;
        vecs.push_back(mk(0, 1, 0, 0, 3'd1, 3'd6, 4'd2, 3'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd1, 3'd6, 4'd2, 3'd2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd1, 3'd6, 4'd2, 3'd3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3'd1, 3'd6, 4'd2, 3'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3'd1, 3'd6, 4'd2, 3'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd0, 3'd5, 4'd1, 3'd0, 0, 1, 0, 0));
        for (int v = 1; v <= 5; v++)
            vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd5, 4'd1, 3'(v), 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd5, 4'd1, 3'd4, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd5, 4'd1, 3'd3, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3'd0, 3'd5, 4'd1, 3'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3'd5, 4'd1, 3'd0, 0, 0, 0, 0));
`endif

        foreach (vecs[i]) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            chk(sb.pop_front());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
